// File: rtl/result_reader.sv
// result_reader: drains the cpu result stack into byte frames on a valid/ready stream.
// Each popped 64-bit result is sent as a tag byte followed by eight payload bytes.
// Once the stack is empty and a trap code is present, a two-byte trap frame is sent
// and the block halts until reset.
module result_reader #(
  parameter bit         BIG_ENDIAN = 1'b0,
  parameter logic [7:0] RESULT_TAG = 8'h52,
  parameter logic [7:0] TRAP_TAG   = 8'h54
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] result,
  input  logic        result_empty,
  output logic        result_pop,
  input  logic [3:0]  trap,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StSend,
    StTrap,
    StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [63:0] payload_q, payload_d;
  logic [3:0]  trap_q, trap_d;

  // Payload byte for the current index; index 0 is the tag, so payload uses 1..8.
  logic [2:0]  byte_sel;
  logic [7:0]  payload_byte;

  // Byte lane selection for the payload, depending on endianness.
  always_comb begin
    if (BIG_ENDIAN) begin
      byte_sel = 3'(4'd8 - idx_q);
    end else begin
      byte_sel = 3'(idx_q - 4'd1);
    end
    payload_byte = payload_q[{byte_sel, 3'b000} +: 8];
  end

  // Next-state logic: results always drain before a trap is reported.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    payload_d = payload_q;
    trap_d    = trap_q;
    unique case (state_q)
      StIdle: begin
        if (!result_empty) begin
          state_d = StPop;
        end else if (trap != 4'h0) begin
          trap_d  = trap;
          idx_d   = 4'd0;
          state_d = StTrap;
        end
      end
      StPop: begin
        payload_d = result;
        idx_d     = 4'd0;
        state_d   = StSend;
      end
      StSend: begin
        if (tx_ready) begin
          if (idx_q == 4'd8) begin
            idx_d   = 4'd0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StTrap: begin
        if (tx_ready) begin
          if (idx_q == 4'd1) begin
            idx_d   = 4'd0;
            state_d = StHalt;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
        idx_d   = 4'd0;
      end
    endcase
  end

  // Outputs decoded from registered state only; no input-to-output paths.
  always_comb begin
    result_pop = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_data = 8'h00;
      end
      StPop: begin
        result_pop = 1'b1;
        busy       = 1'b1;
      end
      StSend: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = (idx_q == 4'd0) ? RESULT_TAG : payload_byte;
      end
      StTrap: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = (idx_q == 4'd0) ? TRAP_TAG : {4'h0, trap_q};
      end
      StHalt: begin
        done = 1'b1;
      end
      default: begin
        tx_data = 8'h00;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      idx_q     <= 4'd0;
      payload_q <= 64'h0;
      trap_q    <= 4'h0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      payload_q <= payload_d;
      trap_q    <= trap_d;
    end
  end

endmodule

// File: tb/tb_result_reader.sv
// Directed testbench for result_reader: one little-endian and one big-endian instance,
// each fed by a small result-stack model.
module tb_result_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Little-endian instance signals
  logic [63:0] res0;
  logic        empty0;
  logic        pop0;
  logic [3:0]  trap0 = 4'h0;
  logic [7:0]  txd0;
  logic        txv0;
  logic        txr0 = 1'b1;
  logic        busy0;
  logic        done0;

  // Big-endian instance signals
  logic [63:0] res1;
  logic        empty1;
  logic        pop1;
  logic [3:0]  trap1 = 4'h0;
  logic [7:0]  txd1;
  logic        txv1;
  logic        txr1 = 1'b1;
  logic        busy1;
  logic        done1;

  // Stack models: entries 0..depth-1, top at depth-1, depth = loaded - pops.
  logic [63:0] stk0 [0:15];
  logic [63:0] stk1 [0:15];
  int loaded0 = 0;
  int loaded1 = 0;
  int pops0 = 0;
  int pops1 = 0;

  assign empty0 = !(loaded0 > pops0);
  assign empty1 = !(loaded1 > pops1);
  assign res0   = (loaded0 > pops0) ? stk0[loaded0 - pops0 - 1] : 64'h0;
  assign res1   = (loaded1 > pops1) ? stk1[loaded1 - pops1 - 1] : 64'h0;

  always @(posedge clk) begin
    if (pop0) pops0 <= pops0 + 1;
    if (pop1) pops1 <= pops1 + 1;
  end

  result_reader #(
    .BIG_ENDIAN (1'b0),
    .RESULT_TAG (8'h52),
    .TRAP_TAG   (8'h54)
  ) dut_le (
    .clk          (clk),
    .reset        (rst_n),
    .result       (res0),
    .result_empty (empty0),
    .result_pop   (pop0),
    .trap         (trap0),
    .tx_data      (txd0),
    .tx_valid     (txv0),
    .tx_ready     (txr0),
    .busy         (busy0),
    .done         (done0)
  );

  result_reader #(
    .BIG_ENDIAN (1'b1),
    .RESULT_TAG (8'h52),
    .TRAP_TAG   (8'h54)
  ) dut_be (
    .clk          (clk),
    .reset        (rst_n),
    .result       (res1),
    .result_empty (empty1),
    .result_pop   (pop1),
    .trap         (trap1),
    .tx_data      (txd1),
    .tx_valid     (txv1),
    .tx_ready     (txr1),
    .busy         (busy1),
    .done         (done1)
  );

  int nchecks = 0;
  int nerr = 0;

  logic [7:0] cap [0:31];
  logic [7:0] exp_b [0:31];
  int ncap;
  int stall_bad;

  // Record handshaken bytes from one instance; ready follows a 4-cycle pattern.
  task automatic capture(input int which, input int n, input logic [3:0] rpat);
    int k;
    logic pstall;
    logic [7:0] pd;
    logic v;
    logic r;
    logic [7:0] d;
    ncap = 0;
    stall_bad = 0;
    pstall = 1'b0;
    pd = 8'h00;
    k = 0;
    while (ncap < n && k < 300) begin
      @(negedge clk);
      v = (which != 0) ? txv1 : txv0;
      d = (which != 0) ? txd1 : txd0;
      r = rpat[k % 4];
      if (pstall && (!v || d !== pd)) stall_bad++;
      if (which != 0) txr1 = r; else txr0 = r;
      if (v && r) begin
        cap[ncap] = d;
        ncap++;
      end
      pstall = v && !r;
      pd = d;
      k++;
    end
    if (ncap < n) begin
      nchecks++;
      nerr++;
      $display("FAIL capture_timeout got %0d bytes want %0d", ncap, n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    trap0 = 4'h0;
    trap1 = 4'h0;
    txr0 = 1'b1;
    txr1 = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    nchecks++;
    if ({pop0, txv0, busy0, done0} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_flags0 got %b want 0000", {pop0, txv0, busy0, done0});
    end
    nchecks++;
    if (txd0 !== 8'h00) begin
      nerr++;
      $display("FAIL reset_data0 got %h want 00", txd0);
    end
    nchecks++;
    if ({pop1, txv1, busy1, done1, txd1} !== 12'h000) begin
      nerr++;
      $display("FAIL reset_be got %h want 000", {pop1, txv1, busy1, done1, txd1});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    nchecks++;
    if ({pop0, txv0, busy0, done0} !== 4'b0000) begin
      nerr++;
      $display("FAIL idle_after_reset got %b want 0000", {pop0, txv0, busy0, done0});
    end
  endtask

  task automatic test_single();
    int p;
    @(negedge clk);
    p = pops0;
    stk0[0] = 64'd2;
    loaded0 = pops0 + 1;
    txr0 = 1'b1;
    @(negedge clk);
    nchecks++;
    if ({pop0, busy0, txv0} !== 3'b110) begin
      nerr++;
      $display("FAIL single_pop_cycle got %b want 110", {pop0, busy0, txv0});
    end
    capture(0, 9, 4'b1111);
    exp_b[0] = 8'h52;
    exp_b[1] = 8'h02;
    for (int i = 2; i < 9; i++) exp_b[i] = 8'h00;
    for (int i = 0; i < 9; i++) begin
      nchecks++;
      if (cap[i] !== exp_b[i]) begin
        nerr++;
        $display("FAIL single_byte%0d got %h want %h", i, cap[i], exp_b[i]);
      end
    end
    @(negedge clk);
    nchecks++;
    if ({busy0, txv0} !== 2'b00) begin
      nerr++;
      $display("FAIL single_end got %b want 00", {busy0, txv0});
    end
    repeat (10) @(negedge clk);
    nchecks++;
    if (pops0 - p !== 1) begin
      nerr++;
      $display("FAIL single_pops got %0d want 1", pops0 - p);
    end
  endtask

  task automatic test_big_endian();
    int p;
    @(negedge clk);
    p = pops1;
    stk1[0] = 64'h0102030405060708;
    loaded1 = pops1 + 1;
    capture(1, 9, 4'b1001);
    exp_b[0] = 8'h52;
    for (int i = 1; i < 9; i++) exp_b[i] = 8'(i);
    for (int i = 0; i < 9; i++) begin
      nchecks++;
      if (cap[i] !== exp_b[i]) begin
        nerr++;
        $display("FAIL be_byte%0d got %h want %h", i, cap[i], exp_b[i]);
      end
    end
    nchecks++;
    if (stall_bad !== 0) begin
      nerr++;
      $display("FAIL be_stall_stable got %0d unstable want 0", stall_bad);
    end
    txr1 = 1'b1;
    repeat (12) @(negedge clk);
    nchecks++;
    if (pops1 - p !== 1) begin
      nerr++;
      $display("FAIL be_pops got %0d want 1", pops1 - p);
    end
  endtask

  task automatic test_drain_trap();
    int p;
    int bad;
    @(negedge clk);
    p = pops0;
    stk0[0] = 64'd7;
    stk0[1] = 64'd9;
    loaded0 = pops0 + 2;
    trap0 = 4'h3;
    capture(0, 20, 4'b1111);
    for (int i = 0; i < 20; i++) exp_b[i] = 8'h00;
    exp_b[0] = 8'h52;
    exp_b[1] = 8'h09;
    exp_b[9] = 8'h52;
    exp_b[10] = 8'h07;
    exp_b[18] = 8'h54;
    exp_b[19] = 8'h03;
    for (int i = 0; i < 20; i++) begin
      nchecks++;
      if (cap[i] !== exp_b[i]) begin
        nerr++;
        $display("FAIL drain_byte%0d got %h want %h", i, cap[i], exp_b[i]);
      end
    end
    @(negedge clk);
    nchecks++;
    if ({done0, txv0, busy0} !== 3'b100) begin
      nerr++;
      $display("FAIL drain_done got %b want 100", {done0, txv0, busy0});
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txv0 || pop0 || !done0) bad++;
    end
    nchecks++;
    if (bad !== 0) begin
      nerr++;
      $display("FAIL halt_quiet got %0d active cycles want 0", bad);
    end
    nchecks++;
    if (pops0 - p !== 2) begin
      nerr++;
      $display("FAIL drain_pops got %0d want 2", pops0 - p);
    end
  endtask

  task automatic test_trap_latch();
    do_reset();
    txr0 = 1'b0;
    trap0 = 4'h3;
    @(negedge clk);
    nchecks++;
    if ({txv0, txd0} !== {1'b1, 8'h54}) begin
      nerr++;
      $display("FAIL trap_hdr got %b/%h want 1/54", txv0, txd0);
    end
    trap0 = 4'h5;
    @(negedge clk);
    nchecks++;
    if ({txv0, txd0} !== {1'b1, 8'h54}) begin
      nerr++;
      $display("FAIL trap_stall got %b/%h want 1/54", txv0, txd0);
    end
    capture(0, 2, 4'b0110);
    nchecks++;
    if ({cap[0], cap[1]} !== 16'h5403) begin
      nerr++;
      $display("FAIL trap_latch got %h%h want 5403", cap[0], cap[1]);
    end
    nchecks++;
    if (stall_bad !== 0) begin
      nerr++;
      $display("FAIL trap_stall_stable got %0d want 0", stall_bad);
    end
    @(negedge clk);
    nchecks++;
    if (done0 !== 1'b1) begin
      nerr++;
      $display("FAIL trap_done got %b want 1", done0);
    end
  endtask

  task automatic test_reset_midframe();
    int bad;
    do_reset();
    stk0[0] = 64'h1122334455667788;
    loaded0 = pops0 + 1;
    txr0 = 1'b1;
    capture(0, 4, 4'b1111);
    nchecks++;
    if ({cap[0], cap[1]} !== 16'h5288) begin
      nerr++;
      $display("FAIL mid_first got %h%h want 5288", cap[0], cap[1]);
    end
    @(negedge clk);
    nchecks++;
    if ({txv0, txd0} !== {1'b1, 8'h55}) begin
      nerr++;
      $display("FAIL mid_idx4 got %b/%h want 1/55", txv0, txd0);
    end
    rst_n = 1'b0;
    #1;
    nchecks++;
    if ({txv0, pop0, busy0, txd0} !== 11'h000) begin
      nerr++;
      $display("FAIL mid_async got %h want 000", {txv0, pop0, busy0, txd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (txv0 || pop0 || busy0) bad++;
    end
    nchecks++;
    if (bad !== 0) begin
      nerr++;
      $display("FAIL mid_after got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_idle();
    int npop;
    int nval;
    int ndone;
    npop = 0;
    nval = 0;
    ndone = 0;
    trap0 = 4'h0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pop0) npop++;
      if (txv0) nval++;
      if (done0) ndone++;
    end
    nchecks++;
    if (npop !== 0) begin
      nerr++;
      $display("FAIL idle_pop got %0d want 0", npop);
    end
    nchecks++;
    if (nval !== 0) begin
      nerr++;
      $display("FAIL idle_valid got %0d want 0", nval);
    end
    nchecks++;
    if (ndone !== 0) begin
      nerr++;
      $display("FAIL idle_done got %0d want 0", ndone);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_big_endian();
    test_drain_trap();
    test_trap_latch();
    test_reset_midframe();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/result_reader.md
# result_reader

Host-side drain for the cpu result stack. It pops 64-bit values from the cpu's `result`/`result_empty` interface and serialises each one as a byte frame on a valid/ready stream. Once the stack is empty and `trap` is nonzero, it emits a trap frame and halts. It sits between `cpu` and the host link (UART/FIFO bridge), giving software the same view a testbench gets by probing `result` directly.

## Interface
Parameters:
- `BIG_ENDIAN`, default 0. 0 sends payload LSB first; 1 sends MSB first.
- `RESULT_TAG`, default 8'h52. Header byte of a result frame.
- `TRAP_TAG`, default 8'h54. Header byte of a trap frame.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low. 0 resets immediately; release is synchronous to `clk`.
- `result` input 64: top of cpu result stack; valid when `result_empty`=0.
- `result_empty` input 1: cpu result stack empty.
- `result_pop` output 1: one-cycle pulse; the cpu removes the top entry at that rising edge.
- `trap` input 4: cpu trap code; 0 means running or no trap.
- `tx_data` output 8: frame byte.
- `tx_valid` output 1: `tx_data` valid.
- `tx_ready` input 1: sink accepts a byte when `tx_valid`&&`tx_ready` at a rising edge.
- `busy` output 1: a frame is in progress (states POP, SEND, TRAP).
- `done` output 1: trap frame sent; block halted.

## Operation
- States: IDLE, POP, SEND, TRAP, HALT.
- IDLE:
  - If `result_empty`=0, go to POP.
  - Else if `trap`!=0, load the trap frame and go to TRAP.
  - Else stay in IDLE.
  - Results always drain before a trap is reported.
- POP: `result_pop`=1 for exactly this cycle. Latch `result` into the 64-bit payload register. Clear the 4-bit byte index. Go to SEND.
- SEND:
  - `tx_valid`=1.
  - Index 0 sends `RESULT_TAG`.
  - Indices 1..8 send payload byte (index-1) when `BIG_ENDIAN`=0, or byte (8-index) when `BIG_ENDIAN`=1.
  - The index advances only on a handshake.
  - A handshake at index 8 returns to IDLE.
- TRAP: two bytes, `TRAP_TAG` then {4'h0, trap}. The trap code is latched on entry to TRAP, so later `trap` changes are ignored. A handshake on byte 1 goes to HALT.
- HALT: `done`=1 and `tx_valid`=0. Ignores all inputs and never pops. Only `reset` exits.
- `tx_data` and payload are held stable while `tx_valid`=1 and `tx_ready`=0.
- `tx_valid` never drops without a handshake.
- At most one pop per frame. The cpu's `result_empty` update after a pop is guaranteed seen: at least 9 cycles always elapse before IDLE resamples it.

## Timing
- Reset values: `result_pop`=0, `tx_valid`=0, `tx_data`=8'h00, `busy`=0, `done`=0, state IDLE, index 0, payload 0.
- All outputs are registered or decoded from state/index only. There are no combinational paths from inputs to outputs.
- `result_empty` is seen low at edge k:
  - `result_pop`=1 during cycle k..k+1.
  - `tx_valid` with header from edge k+1.
- With `tx_ready` held 1, a result frame occupies 9 consecutive cycles and IDLE is re-entered after the 9th handshake. Minimum pop-to-pop spacing is 11 cycles.
- Trap frame is 2 cycles with `tx_ready`=1. `done` rises on the edge of the second handshake.
- `tx_ready` low stalls indefinitely with no state loss.
- Reset asserted mid-frame:
  - Outputs drop to reset values immediately, asynchronously.
  - The partial frame is discarded and not resent.
  - An entry already popped is lost.

## Test plan
- cpu runs select2.hex (ROM_ADDR 4), `tx_ready`=1 → exactly one `result_pop`, then bytes 52 02 00 00 00 00 00 00 00, then `busy`=0.
- `BIG_ENDIAN`=1, stack holds 64'h0102030405060708, `tx_ready` toggling 1,0,0,1 → bytes 52 01 02 03 04 05 06 07 08. `tx_data` is stable during every stall. One pop.
- Stack model preloaded with 7 and 9, `trap`=4'h3 from start → frame for top value, frame for the other, then 54 03. `done`=1 and no further pops or `tx_valid`.
- `trap` changes 3→5 during the trap frame's first-byte stall → second byte is still 8'h03.
- `reset` pulsed low at byte index 4 of a frame → `tx_valid`/`result_pop`/`busy` go 0 before the next edge. After release with stack empty and `trap`=0, the block stays IDLE with no output.
- `result_empty`=1 and `trap`=0 for 100 cycles → no pop, no `tx_valid`, `done`=0.
